// File: rtl/receiver_readout_scheduler.sv
// Round-robin readout scheduler that drains decoded BMC blocks from N_RX receiver RAMs onto one valid/ready stream.
// Define SCHED_STATS_EN to build the saturating blocks_sent / timeout_cnt counters; otherwise they are tied to 0.
module receiver_readout_scheduler #(
   parameter int N_RX           = 4,
   parameter int MAX_BURST      = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                clk_96MHz,
   input  logic                reset_n,
   input  logic [N_RX-1:0]     rx_enable,
   input  logic [N_RX*8-1:0]   avl_blocks_nb,
   input  logic [N_RX*41-1:0]  block_wanted,
   input  logic [N_RX-1:0]     data_ready,
   output logic [N_RX*8-1:0]   block_wanted_number,
   output logic [N_RX-1:0]     clear_blocks,
   output logic [7:0]          clear_count,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [3:0]          out_rx_id,
   output logic [40:0]         out_block,
   output logic                busy,
   output logic                timeout_err,
   output logic [15:0]         blocks_sent,
   output logic [7:0]          timeout_cnt
);

   localparam int IW = (N_RX > 1) ? $clog2(N_RX) : 1;

   typedef enum logic [2:0] {IDLE, REQUEST, WAIT, OUTPUT, CLEAR, ABORT} state_t;

   state_t        state;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] gnt;
   logic [IW-1:0] gnt_next;
   logic [7:0]    burst;
   logic [7:0]    idx;
   logic [7:0]    tmo;
   logic          found;
   logic [IW-1:0] cand;
   logic [7:0]    cand_avl;
   logic          timeout_hit;

   // Scan from the highest offset down so the receiver closest to rr_ptr is the one left in cand.
   // NOTE: every always_comb output gets a default first, otherwise a path that skips it infers a latch.
   always_comb begin
      found = 1'b0;
      cand  = '0;
      for (int k = N_RX-1; k >= 0; k--) begin
         if (rx_enable[(int'(rr_ptr) + k) % N_RX] &&
             avl_blocks_nb[8*((int'(rr_ptr) + k) % N_RX) +: 8] != 8'd0) begin
            found = 1'b1;
            cand  = IW'((int'(rr_ptr) + k) % N_RX);
         end
      end
   end

   assign cand_avl    = avl_blocks_nb[8*int'(cand) +: 8];
   assign gnt_next    = (gnt == IW'(N_RX-1)) ? '0 : gnt + 1'b1;
   assign timeout_hit = (state == WAIT) && !data_ready[gnt] && (tmo == 8'd1);
   assign busy        = (state != IDLE);

   // NOTE: reset is synchronous and state uses non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk_96MHz) begin
      if (!reset_n) begin
         state               <= IDLE;
         rr_ptr              <= '0;
         gnt                 <= '0;
         burst               <= '0;
         idx                 <= '0;
         tmo                 <= '0;
         block_wanted_number <= '0;
         clear_blocks        <= '0;
         clear_count         <= '0;
         out_valid           <= 1'b0;
         out_rx_id           <= '0;
         out_block           <= '0;
         timeout_err         <= 1'b0;
      end else begin
         clear_blocks <= '0;
         clear_count  <= '0;
         case (state)
            IDLE: begin
               if (found) begin
                  gnt   <= cand;
                  burst <= (cand_avl > 8'(MAX_BURST)) ? 8'(MAX_BURST) : cand_avl;
                  idx   <= '0;
                  block_wanted_number[8*int'(cand) +: 8] <= 8'd0;
                  state <= REQUEST;
               end
            end
            REQUEST: begin
               tmo   <= 8'(TIMEOUT_CYCLES);
               state <= WAIT;
            end
            WAIT: begin
               if (data_ready[gnt]) begin
                  out_block <= block_wanted[41*int'(gnt) +: 41];
                  out_rx_id <= 4'(gnt);
                  out_valid <= 1'b1;
                  state     <= OUTPUT;
               end else if (tmo == 8'd1) begin
                  timeout_err <= 1'b1;
                  state       <= ABORT;
               end else begin
                  tmo <= tmo - 8'd1;
               end
            end
            OUTPUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  idx       <= idx + 8'd1;
                  if (idx + 8'd1 == burst) begin
                     clear_blocks <= N_RX'(1) << gnt;
                     clear_count  <= burst;
                     state        <= CLEAR;
                  end else begin
                     block_wanted_number[8*int'(gnt) +: 8] <= idx + 8'd1;
                     state <= REQUEST;
                  end
               end
            end
            CLEAR, ABORT: begin
               rr_ptr <= gnt_next;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SCHED_STATS_EN
   always_ff @(posedge clk_96MHz) begin
      if (!reset_n) begin
         blocks_sent <= '0;
         timeout_cnt <= '0;
      end else begin
         if (out_valid && out_ready && blocks_sent != 16'hFFFF)
            blocks_sent <= blocks_sent + 16'd1;
         if (timeout_hit && timeout_cnt != 8'hFF)
            timeout_cnt <= timeout_cnt + 8'd1;
      end
   end
`else
   assign blocks_sent = '0;
   assign timeout_cnt = '0;
   logic unused_stats;
   assign unused_stats = timeout_hit;
`endif

endmodule
